rc4_block_loader: RTL and testbench

- Upstream input stage for the RC4 cipher core.
- Accepts a serial byte stream over a valid/ready handshake, tagged as either key or plaintext.
- Assembles N-byte Key and P words and presents them as one block with a valid/ready handshake.
- The key is retained across blocks until it is explicitly cleared and reloaded.

---
 rtl/rc4_block_loader.sv | 132 +++++++++++++
 tb/tb_rc4_block_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rc4_block_loader.sv
`default_nettype none
// ============================================================================
// Module  : rc4_block_loader
// Brief   : Packs a tagged key/plaintext byte stream into N-byte Key/P blocks
//           for the RC4 core; the key persists across blocks until cleared.
// Revision: 1.0
// ============================================================================
module rc4_block_loader #(
  parameter int N = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  input  logic             in_is_key,
  output logic             in_ready,
  input  logic             key_clr,
  output logic [8*N-1:0]   P,
  output logic [8*N-1:0]   Key,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             key_loaded,
  output logic [7:0]       blk_count
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_FULL = CW'(N);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [8*N-1:0]  r_key;
  logic [8*N-1:0]  r_p;
  logic [CW-1:0]   r_key_cnt;
  logic [CW-1:0]   r_pt_cnt;
  logic [CW-1:0]   w_key_cnt_nxt;
  logic [CW-1:0]   w_pt_cnt_nxt;
  logic            r_key_loaded;
  logic [7:0]      r_blk_count;
  logic            w_in_ready;
  logic            w_key_we;
  logic            w_pt_we;
  logic            w_handoff;

  always_comb begin
    w_in_ready    = 1'b0;
    w_key_we      = 1'b0;
    w_pt_we       = 1'b0;
    w_handoff     = 1'b0;
    w_key_cnt_nxt = r_key_cnt;
    w_pt_cnt_nxt  = r_pt_cnt;
    w_state_nxt   = r_state;
    case (r_state)
      S_FILL: begin
        // Each tag has its own room check so a full key never blocks plaintext.
        w_in_ready = !key_clr && (in_is_key ? (r_key_cnt < C_FULL)
                                            : (r_pt_cnt < C_FULL));
        w_key_we   = in_valid && w_in_ready && in_is_key;
        w_pt_we    = in_valid && w_in_ready && !in_is_key;
        if (key_clr) begin
          w_key_cnt_nxt = '0;
        end else if (w_key_we) begin
          w_key_cnt_nxt = r_key_cnt + CW'(1);
        end
        if (w_pt_we) begin
          w_pt_cnt_nxt = r_pt_cnt + CW'(1);
        end
        if ((w_key_cnt_nxt == C_FULL) && (w_pt_cnt_nxt == C_FULL)) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_handoff = blk_ready;
        if (blk_ready) begin
          w_pt_cnt_nxt = '0;
          w_state_nxt  = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_key_cnt    <= '0;
      r_pt_cnt     <= '0;
      r_key_loaded <= 1'b0;
      r_blk_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_key_cnt    <= w_key_cnt_nxt;
      r_pt_cnt     <= w_pt_cnt_nxt;
      r_key_loaded <= (w_key_cnt_nxt == C_FULL);
      if (w_handoff) begin
        r_blk_count <= r_blk_count + 8'd1;
      end
    end
  end

  // First byte of each word lands in the most significant lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
      r_p   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_key_we && (r_key_cnt == CW'(N - 1 - i))) begin
          r_key[8*i +: 8] <= in_byte;
        end
        if (w_pt_we && (r_pt_cnt == CW'(N - 1 - i))) begin
          r_p[8*i +: 8] <= in_byte;
        end
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign P          = r_p;
  assign Key        = r_key;
  assign blk_valid  = (r_state == S_HOLD);
  assign key_loaded = r_key_loaded;
  assign blk_count  = r_blk_count;

endmodule
`default_nettype wire

// File: tb/tb_rc4_block_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_rc4_block_loader
// Brief   : Self-checking bench for rc4_block_loader with a byte-array model.
// Revision: 1.0
// ============================================================================
module tb_rc4_block_loader;

  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [7:0]     in_byte = 8'h00;
  logic           in_is_key = 1'b0;
  logic           in_ready;
  logic           key_clr = 1'b0;
  logic [8*N-1:0] P;
  logic [8*N-1:0] Key;
  logic           blk_valid;
  logic           blk_ready = 1'b0;
  logic           key_loaded;
  logic [7:0]     blk_count;

  int checks = 0;
  int failures = 0;

  rc4_block_loader #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
    .in_is_key(in_is_key), .in_ready(in_ready), .key_clr(key_clr),
    .P(P), .Key(Key), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .key_loaded(key_loaded), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  // Reference model: bytes kept in arrival order, packed only when compared.
  logic [7:0] mk [N];
  logic [7:0] mp [N];
  int         m_kc, m_pc;
  bit         m_hold, m_kl;
  logic [7:0] m_cnt;

  function automatic logic [8*N-1:0] pack(input logic [7:0] b [N]);
    logic [8*N-1:0] v = '0;
    for (int i = 0; i < N; i++) v = {v[8*N-9:0], b[i]};
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_kl = 0; m_kc = 0; m_pc = 0; m_cnt = 8'd0;
      for (int i = 0; i < N; i++) begin mk[i] = 8'h00; mp[i] = 8'h00; end
    end else if (!m_hold) begin
      if (key_clr) begin
        m_kc = 0; m_kl = 0;
      end else if (in_valid) begin
        if (in_is_key && m_kc < N) begin
          mk[m_kc] = in_byte; m_kc++;
          m_kl = (m_kc == N);
        end else if (!in_is_key && m_pc < N) begin
          mp[m_pc] = in_byte; m_pc++;
        end
      end
      if (m_kc == N && m_pc == N) m_hold = 1;
    end else if (blk_ready) begin
      m_hold = 0; m_pc = 0; m_cnt = m_cnt + 8'd1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("in_ready", 64'(in_ready),
          64'(!m_hold && !key_clr && (in_is_key ? (m_kc < N) : (m_pc < N))));
      chk("blk_valid", 64'(blk_valid), 64'(m_hold));
      chk("key_loaded", 64'(key_loaded), 64'(m_kl));
      chk("blk_count", 64'(blk_count), 64'(m_cnt));
      chk("Key", 64'(Key), 64'(pack(mk)));
      chk("P", 64'(P), 64'(pack(mp)));
    end
  end

  task automatic drive(input logic v, input logic [7:0] b, input logic k,
                       input logic c, input logic r);
    @(negedge clk);
    in_valid = v; in_byte = b; in_is_key = k; key_clr = c; blk_ready = r;
  endtask

  task automatic send(input logic [7:0] b, input logic k, input logic r);
    int t = 0;
    drive(1'b1, b, k, 1'b0, r);
    #1;
    while (!in_ready && t < 40) begin
      drive(1'b1, b, k, 1'b0, r);
      #1;
      t++;
    end
    if (t >= 40) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=stalled expected=accept byte=%h", b);
    end
  endtask

  task automatic idle(input logic r);
    drive(1'b0, 8'h00, 1'b0, 1'b0, r);
  endtask

  initial begin
    // Reset asserted mid-fill
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h11, 1, 1); send(8'h22, 1, 1); send(8'h33, 1, 1);
    idle(1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_key_loaded", 64'(key_loaded), 64'd0);
    chk("rst_PK", 64'({P, Key}), 64'd0);
    chk("rst_blk_count", 64'(blk_count), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic block
    for (int i = 1; i <= 5; i++) send(8'(i), 1, 1);
    for (int i = 1; i <= 5; i++) send(8'(8'h40 + i), 0, 1);
    idle(1); #1;
    chk("basic_valid", 64'(blk_valid), 64'd1);
    chk("basic_key", 64'(Key), 64'h0102030405);
    chk("basic_p", 64'(P), 64'h4142434445);
    idle(1); #1;
    chk("basic_valid_drop", 64'(blk_valid), 64'd0);
    chk("basic_count", 64'(blk_count), 64'd1);

    // Interleave with a stalled sixth key byte
    repeat (2) @(negedge clk);
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);  // clear key first
    for (int i = 0; i < 4; i++) begin
      send(8'(8'hA0 + i), 1, 1);
      send(8'(8'h50 + i), 0, 1);
    end
    send(8'hA4, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1); #1;
      chk("sixth_key_stall", 64'(in_ready), 64'd0);
    end
    send(8'h54, 0, 1);
    idle(1); #1;
    chk("ilv_key", 64'(Key), 64'hA0A1A2A3A4);
    chk("ilv_p", 64'(P), 64'h5051525354);

    // Backpressure with ignored key_clr in HOLD
    idle(1);
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h77, 1'b1, i == 1, 1'b0); #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_p", 64'(P), 64'h6061626364);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); #1;
    chk("bp_key_kept", 64'(key_loaded), 64'd1);
    idle(1); #1;
    chk("bp_count", 64'(blk_count), 64'd3);

    // Key reuse, then clear and reload
    for (int i = 0; i < 5; i++) send(8'(8'h70 + i), 0, 1);
    idle(1); idle(1); #1;
    chk("reuse_count", 64'(blk_count), 64'd4);
    drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b1); #1;
    chk("clr_no_accept", 64'(in_ready), 64'd0);
    idle(1); #1;
    chk("clr_key_loaded", 64'(key_loaded), 64'd0);
    for (int i = 0; i < 5; i++) send(8'(8'hAA + 17 * i), 1, 1);
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 0, 1);
    idle(1); #1;
    chk("reload_key", 64'(Key), 64'hAABBCCDDEE);
    idle(1); #1;
    chk("reload_count", 64'(blk_count), 64'd5);

    // Wrap: 256 plaintext-only blocks
    for (int b = 0; b < 256; b++) begin
      for (int i = 0; i < 5; i++) send(8'($urandom), 0, 1);
    end
    idle(1); idle(1); #1;
    chk("wrap_count", 64'(blk_count), 64'd5);
    chk("wrap_key", 64'(Key), 64'hAABBCCDDEE);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
    end
    idle(1); idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
